// File: rtl/freq_gate_bcd_counter.sv
// Gated rising-edge counter: four cascaded BCD decades latched once per gate.
// Define OVF_SAT_EN to saturate the digits at 9999 and report overflow.
module freq_gate_bcd_counter #(
  parameter int GATE_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        sig_in,
  output logic [15:0] BCDfreq,
  output logic        freq_valid,
  output logic        overflow
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic          s1_q, s2_q, s3_q;
  logic          e;
  logic [GW-1:0] gate_q, gate_d;
  logic [15:0]   dig_q, dig_d;
  logic [15:0]   bcd_q;
  logic          valid_q;
  logic          count_en, clear, publish;

  // Ripple +1 across the four decades in one cycle.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign e = s2_q & ~s3_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = COUNT;
      end
      COUNT: begin
        if (!run)                    state_d = IDLE;
        else if (gate_q == GATE_LAST) state_d = LATCH;
      end
      LATCH: begin
        state_d = run ? COUNT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_en = 1'b0;
    clear    = 1'b0;
    publish  = 1'b0;
    unique case (state_q)
      IDLE:  clear = 1'b1;
      COUNT: count_en = 1'b1;
      LATCH: begin
        publish = 1'b1;
        clear   = 1'b1;
      end
      default: clear = 1'b1;
    endcase
  end

`ifdef OVF_SAT_EN
  logic ovf_q, ovf_d, ovf_out_q;

  always_comb begin
    gate_d = gate_q;
    dig_d  = dig_q;
    ovf_d  = ovf_q;
    if (clear) begin
      gate_d = '0;
      dig_d  = '0;
      ovf_d  = 1'b0;
    end else if (count_en) begin
      gate_d = gate_q + 1'b1;
      if (e) begin
        if (dig_q == 16'h9999) ovf_d = 1'b1;
        else                   dig_d = bcd_inc(dig_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (publish) ovf_out_q <= ovf_q;
    end
  end

  assign overflow = ovf_out_q;
`else
  always_comb begin
    gate_d = gate_q;
    dig_d  = dig_q;
    if (clear) begin
      gate_d = '0;
      dig_d  = '0;
    end else if (count_en) begin
      gate_d = gate_q + 1'b1;
      if (e) dig_d = bcd_inc(dig_q);
    end
  end

  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate_q  <= '0;
      dig_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      gate_q  <= gate_d;
      dig_q   <= dig_d;
      valid_q <= publish;
      if (publish) bcd_q <= dig_q;
    end
  end

  assign BCDfreq    = bcd_q;
  assign freq_valid = valid_q;

endmodule

// File: tb/tb_freq_gate_bcd_counter.sv
// Bench for freq_gate_bcd_counter: vector table, corner sequences and a
// gate-window reference model over randomized input edges.
module tb_freq_gate_bcd_counter;

  localparam int GA = 100;
  localparam int GB = 2000;
  localparam int GC = 40000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sig = 1'b0;
  logic        run_a = 1'b0, run_b = 1'b0, run_c = 1'b0;
  logic [15:0] bcd_a, bcd_b, bcd_c;
  logic        v_a, v_b, v_c;
  logic        o_a, o_b, o_c;

  always #5 clk = ~clk;

  freq_gate_bcd_counter #(.GATE_CYCLES(GA)) dut_a (
    .clk(clk), .reset(reset), .run(run_a), .sig_in(sig),
    .BCDfreq(bcd_a), .freq_valid(v_a), .overflow(o_a)
  );
  freq_gate_bcd_counter #(.GATE_CYCLES(GB)) dut_b (
    .clk(clk), .reset(reset), .run(run_b), .sig_in(sig),
    .BCDfreq(bcd_b), .freq_valid(v_b), .overflow(o_b)
  );
  freq_gate_bcd_counter #(.GATE_CYCLES(GC)) dut_c (
    .clk(clk), .reset(reset), .run(run_c), .sig_in(sig),
    .BCDfreq(bcd_c), .freq_valid(v_c), .overflow(o_c)
  );

  typedef struct {
    int          per;
    int          hi;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [6];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gmode = 0;
  int per = 10;
  int hi = 5;
  int hold = 0;
  logic sig_prev = 1'b0;
  int rises[$];

  bit          sb_on = 1'b0;
  int          sb_s = 0;
  logic [15:0] sb_bcd = 16'h0000;

  int t1, t2, r0, s0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10),
            4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  // An input rise driven during cycle r is seen as an edge in cycle r+2.
  function automatic int count_in(input int lo, input int last);
    int n = 0;
    foreach (rises[i])
      if (rises[i] + 2 >= lo && rises[i] + 2 <= last) n++;
    return n;
  endfunction

  task automatic set_sig(input logic v);
    if (v && !sig_prev) rises.push_back(cyc);
    sig = v;
    sig_prev = v;
  endtask

  // Gates of GA cycles repeat every GA+1 cycles from sb_s; each result is
  // visible the cycle after its one-cycle latch slot.
  task automatic sb_check();
    int k, lo;
    k = cyc - sb_s - GA - 1;
    if (k >= 0 && k % (GA + 1) == 0) begin
      lo = sb_s + (k / (GA + 1)) * (GA + 1);
      sb_bcd = to_bcd(count_in(lo, lo + GA - 1) % 10000);
      chk("sb_valid", 32'(v_a), 1);
      chk("sb_bcd", 32'(bcd_a), 32'(sb_bcd));
    end else begin
      chk("sb_valid", 32'(v_a), 0);
      chk("sb_hold", 32'(bcd_a), 32'(sb_bcd));
    end
    chk("sb_ovf", 32'(o_a), 0);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (sb_on) sb_check();
    case (gmode)
      1: set_sig((cyc % per) < hi);
      2: begin
        if (hold == 0) begin
          set_sig(~sig);
          hold = $urandom_range(2, 6);
        end
        hold--;
      end
      default: ;
    endcase
  endtask

  task automatic wait_valid(input int which, input int bound,
                            output int at);
    logic v;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (which == 1) begin
        chk("digit_le9", 32'((bcd_b[15:12] > 4'd9) || (bcd_b[11:8] > 4'd9) ||
                             (bcd_b[7:4] > 4'd9) || (bcd_b[3:0] > 4'd9)), 0);
      end
      v = (which == 0) ? v_a : (which == 1) ? v_b : v_c;
      if (v) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      failures++;
      $display("FAIL wait_valid dut%0d: no freq_valid within %0d cycles",
               which, bound);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4,  2,  16'h0025};
    tbl[1] = '{5,  2,  16'h0020};
    tbl[2] = '{20, 10, 16'h0005};
    tbl[3] = '{50, 25, 16'h0002};
    tbl[4] = '{25, 3,  16'h0004};
    tbl[5] = '{10, 5,  16'h0010};

    repeat (3) step();
    chk("rst_bcd_a", 32'(bcd_a), 0);
    chk("rst_v_a", 32'(v_a), 0);
    chk("rst_o_a", 32'(o_a), 0);
    chk("rst_bcd_b", 32'(bcd_b), 0);
    chk("rst_v_b", 32'(v_b), 0);
    chk("rst_bcd_c", 32'(bcd_c), 0);
    chk("rst_o_c", 32'(o_c), 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      gmode = 1;
      per = tbl[i].per;
      hi = tbl[i].hi;
      repeat (110) step();
      run_a = 1'b1;
      wait_valid(0, 300, t1);
      chk("basic_first", 32'(bcd_a), 32'(tbl[i].exp));
      wait_valid(0, 300, t2);
      chk("basic_period", 32'(t2 - t1), GA + 1);
      chk("basic_second", 32'(bcd_a), 32'(tbl[i].exp));
      run_a = 1'b0;
      repeat (3) step();
    end

    // Abort 50 cycles into a gate, then restart.
    repeat (110) step();
    run_a = 1'b1;
    wait_valid(0, 300, t1);
    chk("abort_pre", 32'(bcd_a), 16'h0010);
    repeat (49) step();
    run_a = 1'b0;
    repeat (250) begin
      step();
      chk("abort_no_valid", 32'(v_a), 0);
      chk("abort_hold", 32'(bcd_a), 16'h0010);
    end
    run_a = 1'b1;
    r0 = cyc;
    wait_valid(0, 300, t2);
    chk("abort_latency", 32'(t2 - (r0 + 1)), GA + 1);
    chk("abort_result", 32'(bcd_a), 16'h0010);

    // Asynchronous reset while COUNT is running.
    wait_valid(0, 150, t1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_bcd", 32'(bcd_a), 0);
    chk("async_rst_valid", 32'(v_a), 0);
    chk("async_rst_ovf", 32'(o_a), 0);
    run_a = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (300) begin
      step();
      chk("post_rst_bcd", 32'(bcd_a), 0);
      chk("post_rst_valid", 32'(v_a), 0);
    end

    // Edge on the terminal COUNT cycle, then one on a LATCH cycle.
    gmode = 0;
    set_sig(1'b0);
    repeat (5) step();
    rises.delete();
    sb_bcd = 16'h0000;
    run_a = 1'b1;
    s0 = cyc + 1;
    sb_s = s0;
    sb_on = 1'b1;
    while (cyc < s0 + 310) begin
      step();
      if (cyc == s0 + 97)  set_sig(1'b1);
      if (cyc == s0 + 99)  set_sig(1'b0);
      if (cyc == s0 + 199) set_sig(1'b1);
      if (cyc == s0 + 201) set_sig(1'b0);
      if (cyc == s0 + 101) chk("edge_terminal_in", 32'(bcd_a), 16'h0001);
      if (cyc == s0 + 202) chk("edge_latch_out2", 32'(bcd_a), 16'h0000);
      if (cyc == s0 + 303) chk("edge_latch_out3", 32'(bcd_a), 16'h0000);
    end

    // Random input against the gate-window model.
    hold = 3;
    gmode = 2;
    repeat (1500) step();
    sb_on = 1'b0;
    run_a = 1'b0;

    // 500 edges across the decade carries.
    gmode = 1;
    per = 4;
    hi = 2;
    repeat (10) step();
    run_b = 1'b1;
    wait_valid(1, GB + 50, t1);
    chk("decade_bcd", 32'(bcd_b), 16'h0500);
    chk("decade_ovf", 32'(o_b), 0);
    run_b = 1'b0;

    // 10000 edges in one gate.
    run_c = 1'b1;
    wait_valid(2, GC + 50, t1);
`ifdef OVF_SAT_EN
    chk("ovf_bcd", 32'(bcd_c), 16'h9999);
    chk("ovf_flag", 32'(o_c), 1);
`else
    chk("ovf_bcd", 32'(bcd_c), 16'h0000);
    chk("ovf_flag", 32'(o_c), 0);
`endif
    run_c = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
